// File: rtl/mem_access_unit.sv
// mem_access_unit
// Load/store unit sitting between the execute stage and a simple
// request/acknowledge memory port. It passes ALU results straight to
// writeback, and issues aligned byte/half/word loads and stores with a bus
// timeout. Misaligned accesses complete immediately with exc_align.
//
// Ports
//   clk, rst                       clock (rising edge), synchronous active-high reset
//   in_valid / in_ready            upstream operation handshake
//   in_op, in_wdata, in_waddr,     operation code, ALU result, destination register,
//   in_wr, in_addr, in_sdata       write request, byte address, store data
//   mem_req, mem_we, mem_addr,     memory request, direction, lane-aligned address,
//   mem_be, mem_wdata              byte enables, replicated store data
//   mem_ack, mem_rdata             memory completion and read data
//   wb_valid, wb_data, wb_addr,    one-cycle writeback pulse with data, register
//   wb_wr, exc_align, exc_bus      and write enable, plus exception flags
module mem_access_unit #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int RADDR_W = 5,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_op,
    input  logic [DATA_W-1:0]     in_wdata,
    input  logic [RADDR_W-1:0]    in_waddr,
    input  logic                  in_wr,
    input  logic [ADDR_W-1:0]     in_addr,
    input  logic [DATA_W-1:0]     in_sdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  wb_valid,
    output logic [DATA_W-1:0]     wb_data,
    output logic [RADDR_W-1:0]    wb_addr,
    output logic                  wb_wr,
    output logic                  exc_align,
    output logic                  exc_bus
);

    localparam int LANES  = DATA_W / 8;
    localparam int LANE_W = $clog2(LANES);

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t                state_r, state_nxt_s;
    logic [15:0]           cnt_r, cnt_nxt_s;

    // decode of the incoming operation
    logic                  is_load_s, is_store_s, mem_op_s, sign_s, misalign_s;
    logic [1:0]            size_s;
    logic [LANE_W-1:0]     in_lane_s;
    logic [3:0]            be_base_s;
    logic [LANES-1:0]      be_s;
    logic [DATA_W-1:0]     rep_wdata_s;
    logic                  accept_s, issue_s, timeout_hit_s;

    // context of the access in flight
    logic [1:0]            size_r;
    logic                  sign_r, store_r, wr_r;
    logic [LANE_W-1:0]     lane_r;
    logic [RADDR_W-1:0]    waddr_r;

    // memory-side and writeback registers
    logic                  mem_req_r, mem_we_r;
    logic [ADDR_W-1:0]     mem_addr_r;
    logic [LANES-1:0]      mem_be_r;
    logic [DATA_W-1:0]     mem_wdata_r;
    logic                  wb_valid_r, wb_wr_r, exc_align_r, exc_bus_r;
    logic [DATA_W-1:0]     wb_data_r;
    logic [RADDR_W-1:0]    wb_addr_r;

    logic                  mem_req_nxt_s, wb_valid_nxt_s, wb_wr_nxt_s;
    logic                  exc_align_nxt_s, exc_bus_nxt_s;
    logic [DATA_W-1:0]     wb_data_nxt_s;
    logic [RADDR_W-1:0]    wb_addr_nxt_s;

    logic [DATA_W-1:0]     rdata_shift_s, load_data_s;

    assign in_ready      = (state_r == ST_IDLE) && !rst;
    assign accept_s      = in_valid && in_ready;
    assign mem_op_s      = is_load_s || is_store_s;
    assign issue_s       = accept_s && mem_op_s && !misalign_s;
    assign timeout_hit_s = (cnt_r == 16'(TIMEOUT - 1));
    assign in_lane_s     = in_addr[LANE_W-1:0];

    // Operation decode; unlisted codes behave as PASS.
    always_comb begin
        is_load_s  = 1'b0;
        is_store_s = 1'b0;
        size_s     = SZ_B;
        sign_s     = 1'b0;
        case (in_op)
            4'd1:    begin is_load_s  = 1'b1; size_s = SZ_B; sign_s = 1'b1; end
            4'd2:    begin is_load_s  = 1'b1; size_s = SZ_B; sign_s = 1'b0; end
            4'd3:    begin is_load_s  = 1'b1; size_s = SZ_H; sign_s = 1'b1; end
            4'd4:    begin is_load_s  = 1'b1; size_s = SZ_H; sign_s = 1'b0; end
            4'd5:    begin is_load_s  = 1'b1; size_s = SZ_W; sign_s = 1'b1; end
            4'd9:    begin is_store_s = 1'b1; size_s = SZ_B; end
            4'd10:   begin is_store_s = 1'b1; size_s = SZ_H; end
            4'd11:   begin is_store_s = 1'b1; size_s = SZ_W; end
            default: begin is_load_s  = 1'b0; is_store_s = 1'b0; end
        endcase
    end

    // Alignment check against the natural size of the access.
    always_comb begin
        if (size_s == SZ_H) begin
            misalign_s = in_addr[0];
        end else if (size_s == SZ_W) begin
            misalign_s = (in_addr[1:0] != 2'b00);
        end else begin
            misalign_s = 1'b0;
        end
    end

    // Byte-enable pattern at the lane and store data replicated over the bus.
    always_comb begin
        case (size_s)
            SZ_B: begin
                be_base_s   = 4'b0001;
                rep_wdata_s = {LANES{in_sdata[7:0]}};
            end
            SZ_H: begin
                be_base_s   = 4'b0011;
                rep_wdata_s = {(LANES/2){in_sdata[15:0]}};
            end
            default: begin
                be_base_s   = 4'b1111;
                rep_wdata_s = {(LANES/4){in_sdata[31:0]}};
            end
        endcase
        be_s = LANES'(be_base_s) << in_lane_s;
    end

    // Load data: bring the addressed lane down to bit 0, then extend.
    always_comb begin
        rdata_shift_s = mem_rdata >> {lane_r, 3'b000};
        case (size_r)
            SZ_B: begin
                if (sign_r) begin
                    load_data_s = {{(DATA_W-7){rdata_shift_s[7]}}, rdata_shift_s[6:0]};
                end else begin
                    load_data_s = {{(DATA_W-8){1'b0}}, rdata_shift_s[7:0]};
                end
            end
            SZ_H: begin
                if (sign_r) begin
                    load_data_s = {{(DATA_W-15){rdata_shift_s[15]}}, rdata_shift_s[14:0]};
                end else begin
                    load_data_s = {{(DATA_W-16){1'b0}}, rdata_shift_s[15:0]};
                end
            end
            default: begin
                // Word loads always sign-extend; on a 32-bit bus this is a pass-through.
                load_data_s = {{(DATA_W-31){rdata_shift_s[31]}}, rdata_shift_s[30:0]};
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: only aligned memory ops leave IDLE; ack or timeout return.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (issue_s) begin
                    state_nxt_s = ST_ACCESS;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (mem_ack || timeout_hit_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ACCESS;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs: next values of the request, counter and writeback registers.
    always_comb begin
        mem_req_nxt_s   = 1'b0;
        cnt_nxt_s       = cnt_r;
        wb_valid_nxt_s  = 1'b0;
        wb_data_nxt_s   = wb_data_r;
        wb_addr_nxt_s   = wb_addr_r;
        wb_wr_nxt_s     = 1'b0;
        exc_align_nxt_s = 1'b0;
        exc_bus_nxt_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && !mem_op_s) begin
                    wb_valid_nxt_s = 1'b1;
                    wb_data_nxt_s  = in_wdata;
                    wb_addr_nxt_s  = in_waddr;
                    wb_wr_nxt_s    = in_wr && (in_waddr != {RADDR_W{1'b0}});
                end else if (accept_s && misalign_s) begin
                    wb_valid_nxt_s  = 1'b1;
                    wb_data_nxt_s   = {DATA_W{1'b0}};
                    wb_addr_nxt_s   = in_waddr;
                    exc_align_nxt_s = 1'b1;
                end else if (issue_s) begin
                    mem_req_nxt_s = 1'b1;
                    cnt_nxt_s     = 16'd0;
                end else begin
                    mem_req_nxt_s = 1'b0;
                end
            end
            ST_ACCESS: begin
                if (mem_ack) begin
                    wb_valid_nxt_s = 1'b1;
                    wb_addr_nxt_s  = waddr_r;
                    if (store_r) begin
                        wb_data_nxt_s = {DATA_W{1'b0}};
                        wb_wr_nxt_s   = 1'b0;
                    end else begin
                        wb_data_nxt_s = load_data_s;
                        wb_wr_nxt_s   = wr_r && (waddr_r != {RADDR_W{1'b0}});
                    end
                end else if (timeout_hit_s) begin
                    wb_valid_nxt_s = 1'b1;
                    wb_addr_nxt_s  = waddr_r;
                    wb_data_nxt_s  = {DATA_W{1'b0}};
                    exc_bus_nxt_s  = 1'b1;
                end else begin
                    mem_req_nxt_s = 1'b1;
                    cnt_nxt_s     = cnt_r + 16'd1;
                end
            end
            default: mem_req_nxt_s = 1'b0;
        endcase
    end

    // Output and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r       <= 16'd0;
            mem_req_r   <= 1'b0;
            wb_valid_r  <= 1'b0;
            wb_data_r   <= {DATA_W{1'b0}};
            wb_addr_r   <= {RADDR_W{1'b0}};
            wb_wr_r     <= 1'b0;
            exc_align_r <= 1'b0;
            exc_bus_r   <= 1'b0;
        end else begin
            cnt_r       <= cnt_nxt_s;
            mem_req_r   <= mem_req_nxt_s;
            wb_valid_r  <= wb_valid_nxt_s;
            wb_data_r   <= wb_data_nxt_s;
            wb_addr_r   <= wb_addr_nxt_s;
            wb_wr_r     <= wb_wr_nxt_s;
            exc_align_r <= exc_align_nxt_s;
            exc_bus_r   <= exc_bus_nxt_s;
        end
    end

    // Access context and bus fields: loaded at issue, held until the access ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_be_r    <= {LANES{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            size_r      <= SZ_B;
            sign_r      <= 1'b0;
            store_r     <= 1'b0;
            lane_r      <= {LANE_W{1'b0}};
            waddr_r     <= {RADDR_W{1'b0}};
            wr_r        <= 1'b0;
        end else if (issue_s) begin
            mem_we_r    <= is_store_s;
            mem_addr_r  <= {in_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
            mem_be_r    <= be_s;
            mem_wdata_r <= rep_wdata_s;
            size_r      <= size_s;
            sign_r      <= sign_s;
            store_r     <= is_store_s;
            lane_r      <= in_lane_s;
            waddr_r     <= in_waddr;
            wr_r        <= in_wr;
        end else begin
            mem_we_r    <= mem_we_r;
            mem_addr_r  <= mem_addr_r;
            mem_be_r    <= mem_be_r;
            mem_wdata_r <= mem_wdata_r;
            size_r      <= size_r;
            sign_r      <= sign_r;
            store_r     <= store_r;
            lane_r      <= lane_r;
            waddr_r     <= waddr_r;
            wr_r        <= wr_r;
        end
    end

    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_be    = mem_be_r;
    assign mem_wdata = mem_wdata_r;
    assign wb_valid  = wb_valid_r;
    assign wb_data   = wb_data_r;
    assign wb_addr   = wb_addr_r;
    assign wb_wr     = wb_wr_r;
    assign exc_align = exc_align_r;
    assign exc_bus   = exc_bus_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit (DATA_W=32, TIMEOUT=4). Drives inputs and
// samples outputs on the falling clock edge; expected results come from a
// byte-level reference model of the load/store rules.
module tb_mem_access_unit;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int RW = 5;
    localparam int TO = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      in_op;
    logic [DW-1:0]   in_wdata;
    logic [RW-1:0]   in_waddr;
    logic            in_wr;
    logic [AW-1:0]   in_addr;
    logic [DW-1:0]   in_sdata;
    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW/8-1:0] mem_be;
    logic [DW-1:0]   mem_wdata;
    logic            mem_ack;
    logic [DW-1:0]   mem_rdata;
    logic            wb_valid;
    logic [DW-1:0]   wb_data;
    logic [RW-1:0]   wb_addr;
    logic            wb_wr;
    logic            exc_align;
    logic            exc_bus;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    mem_access_unit #(
        .DATA_W(DW), .ADDR_W(AW), .RADDR_W(RW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_wdata(in_wdata), .in_waddr(in_waddr), .in_wr(in_wr),
        .in_addr(in_addr), .in_sdata(in_sdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_addr(wb_addr),
        .wb_wr(wb_wr), .exc_align(exc_align), .exc_bus(exc_bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int op_size(input logic [3:0] op);
        case (op)
            4'd1, 4'd2, 4'd9:  return 1;
            4'd3, 4'd4, 4'd10: return 2;
            4'd5, 4'd11:       return 4;
            default:           return 0;
        endcase
    endfunction

    function automatic bit op_store(input logic [3:0] op);
        return (op == 4'd9) || (op == 4'd10) || (op == 4'd11);
    endfunction

    function automatic bit op_signed(input logic [3:0] op);
        return (op == 4'd1) || (op == 4'd3) || (op == 4'd5);
    endfunction

    function automatic logic [3:0] model_be(input int sz, input logic [31:0] addr);
        int v;
        v = ((1 << sz) - 1) << (addr % 4);
        return v[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input int sz, input logic [31:0] sdata);
        logic [31:0] r;
        r = 32'd0;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = sdata[(i % sz)*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [3:0] op, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        longint v, mask;
        int     sz;
        sz   = op_size(op);
        mask = (64'd1 << (8*sz)) - 1;
        v    = (longint'(rdata) >> (8*(addr % 4))) & mask;
        if (op_signed(op) && v[8*sz-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    // One operation from issue to writeback; ack_at is the mem_req cycle
    // (1-based) in which mem_ack is raised, values beyond TO mean never.
    task automatic do_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [31:0] wdata, input logic [4:0] waddr, input logic wr,
                         input int ack_at, input logic [31:0] rdata);
        int sz;
        bit st, timed_out;
        sz = op_size(op);
        st = op_store(op);
        chk("ready_before", in_ready, 1);
        in_valid = 1'b1; in_op = op; in_addr = addr; in_sdata = sdata;
        in_wdata = wdata; in_waddr = waddr; in_wr = wr;
        @(negedge clk);
        in_valid = 1'b0;
        in_op    = 4'($urandom);
        in_addr  = $urandom;
        if (sz == 0) begin
            chk("pass_valid", wb_valid, 1);
            chk("pass_data", wb_data, wdata);
            chk("pass_addr", wb_addr, waddr);
            chk("pass_wr", wb_wr, wr && (waddr != 5'd0));
            chk("pass_exc", {exc_align, exc_bus}, 2'b00);
            chk("pass_noreq", mem_req, 0);
        end else if ((addr % sz) != 0) begin
            chk("mis_valid", wb_valid, 1);
            chk("mis_exc", {exc_align, exc_bus}, 2'b10);
            chk("mis_wr", wb_wr, 0);
            chk("mis_data", wb_data, 0);
            chk("mis_noreq", mem_req, 0);
        end else begin
            chk("acc_novalid", wb_valid, 0);
            timed_out = 1'b0;
            for (int c = 1; c <= TO; c++) begin
                chk("acc_req", mem_req, 1);
                chk("acc_ready", in_ready, 0);
                chk("acc_we", mem_we, st);
                chk("acc_addr", mem_addr, addr & 32'hFFFF_FFFC);
                chk("acc_be", mem_be, model_be(sz, addr));
                if (st) chk("acc_wdata", mem_wdata, model_wdata(sz, sdata));
                if (c == ack_at) begin
                    mem_ack = 1'b1; mem_rdata = rdata;
                end else begin
                    mem_ack = 1'b0; mem_rdata = $urandom;
                end
                @(negedge clk);
                mem_ack = 1'b0;
                if (c == ack_at) break;
                if (c == TO) timed_out = 1'b1;
            end
            chk("done_noreq", mem_req, 0);
            chk("done_valid", wb_valid, 1);
            chk("done_exc", {exc_align, exc_bus}, {1'b0, timed_out});
            chk("done_addr", wb_addr, waddr);
            if (timed_out || st) begin
                chk("done_data0", wb_data, 0);
                chk("done_wr0", wb_wr, 0);
            end else begin
                chk("load_data", wb_data, model_load(op, addr, rdata));
                chk("load_wr", wb_wr, wr && (waddr != 5'd0));
            end
        end
    endtask

    logic [4:0]  pw [3] = '{5'd3, 5'd0, 5'd7};
    logic        pe [3] = '{1'b1, 1'b0, 1'b1};
    logic [3:0]  ops [10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9, 4'd10, 4'd11, 4'd7};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_op = 4'd0; in_wdata = 32'd0; in_waddr = 5'd0;
        in_wr = 1'b0; in_addr = 32'd0; in_sdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;

        // reset state
        @(negedge clk); @(negedge clk);
        chk("rst_ready", in_ready, 0);
        chk("rst_req", {mem_req, mem_we, wb_valid, wb_wr, exc_align, exc_bus}, 6'd0);
        chk("rst_be", mem_be, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_wbdata", wb_data, 0);
        chk("rst_wbaddr", wb_addr, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", in_ready, 1);

        // back-to-back PASS, r0 write suppressed
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_op = 4'd0; in_waddr = pw[i]; in_wr = 1'b1;
            in_wdata = 32'hA000_0000 + i;
            @(negedge clk);
            chk("b2b_valid", wb_valid, 1);
            chk("b2b_wr", wb_wr, pe[i]);
            chk("b2b_addr", wb_addr, pw[i]);
            chk("b2b_data", wb_data, 32'hA000_0000 + i);
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_end", wb_valid, 0);

        // directed loads/stores
        do_op(4'd1, 32'h0000_1003, 32'd0, 32'd0, 5'd4, 1'b1, 3, 32'h80FF_FF11);
        do_op(4'd2, 32'h0000_1003, 32'd0, 32'd0, 5'd4, 1'b1, 3, 32'h80FF_FF11);
        do_op(4'd10, 32'h0000_2002, 32'h1234_ABCD, 32'd0, 5'd6, 1'b1, 1, 32'd0);
        do_op(4'd5, 32'h0000_0006, 32'd0, 32'd0, 5'd8, 1'b1, 1, 32'd0);
        do_op(4'd5, 32'h0000_0100, 32'd0, 32'd0, 5'd9, 1'b1, 99, 32'h1234_5678);
        do_op(4'd5, 32'h0000_0100, 32'd0, 32'd0, 5'd9, 1'b1, 4, 32'h1234_5678);
        do_op(4'd3, 32'h0000_0302, 32'd0, 32'd0, 5'd0, 1'b1, 2, 32'h8001_7FFF);

        // ack while idle is ignored
        mem_ack = 1'b1; mem_rdata = $urandom;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("idle_ack_valid", wb_valid, 0);
        chk("idle_ack_req", mem_req, 0);

        // reset during the second ACCESS cycle abandons the access
        in_valid = 1'b1; in_op = 4'd5; in_addr = 32'h40; in_waddr = 5'd5; in_wr = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rstacc_req1", mem_req, 1);
        @(negedge clk);
        chk("rstacc_req2", mem_req, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstacc_req0", mem_req, 0);
        chk("rstacc_novalid", wb_valid, 0);
        chk("rstacc_ready0", in_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rstacc_ready1", in_ready, 1);
        chk("rstacc_novalid2", wb_valid, 0);

        // randomized operations
        for (int n = 0; n < 60; n++) begin
            do_op(ops[$urandom_range(0, 9)], $urandom & 32'h0000_FFFF, $urandom, $urandom,
                  5'($urandom), 1'($urandom), $urandom_range(1, 6), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DATA_W, 32, data/register width; legal values 32 and 64; LANES = DATA_W/8.
- ADDR_W, 32, byte address width.
- RADDR_W, 5, register address width.
- TIMEOUT, 255, maximum mem_req cycles without mem_ack; legal range 1..65535.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk in 1: clock, rising edge.
- rst in 1: reset, synchronous, active-high.
- in_valid in 1: upstream operation valid.
- in_ready out 1: unit accepts an operation.
- in_op in 4: 0 PASS, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 9 SB, 10 SH, 11 SW; all other codes SHALL be treated as PASS.
- in_wdata in DATA_W: ALU result for PASS.
- in_waddr in RADDR_W: destination register.
- in_wr in 1: destination write request.
- in_addr in ADDR_W: byte address.
- in_sdata in DATA_W: store data.
- mem_req out 1: memory request.
- mem_we out 1: 1 write, 0 read.
- mem_addr out ADDR_W: lane-aligned address, with the low log2(LANES) bits forced to 0.
- mem_be out LANES: byte enables.
- mem_wdata out DATA_W: store data.
- mem_ack in 1: memory completion.
- mem_rdata in DATA_W: read data, valid with mem_ack.
- wb_valid out 1: writeback result valid, one-cycle pulse.
- wb_data out DATA_W: writeback data.
- wb_addr out RADDR_W: writeback register.
- wb_wr out 1: register write enable.
- exc_align out 1: misalignment exception, qualified by wb_valid.
- exc_bus out 1: bus timeout exception, qualified by wb_valid.

Function
REQ-003 FSM SHALL have two states: IDLE and ACCESS; in_ready SHALL be 1 only in IDLE.
REQ-004 Accept SHALL occur when in_valid and in_ready are both 1 at a clock edge; inputs SHALL be registered at accept.
REQ-005 PASS SHALL complete in 1 cycle: on the cycle after accept, wb_valid=1, wb_data=in_wdata, wb_addr=in_waddr, wb_wr=in_wr; the FSM stays in IDLE, giving throughput of 1 op/cycle.
REQ-006 Misalignment SHALL be defined as: LH/LHU/SH with addr[0]≠0; LW/SW with addr[1:0]≠0.
REQ-007 A misaligned op SHALL issue no mem_req; on the next cycle wb_valid=1, exc_align=1, wb_wr=0, wb_data=0.
REQ-008 An aligned load/store SHALL move to ACCESS; mem_req=1 from the cycle after accept.
REQ-009 mem_addr, mem_we, mem_be and mem_wdata SHALL be held stable until mem_ack.
REQ-010 Byte lane SHALL be addr[log2(LANES)-1:0].
REQ-011 mem_be SHALL be: SB one bit at lane; SH two bits at lane, lane+1; SW four bits at lane..lane+3; loads drive the same pattern with mem_we=0.
REQ-012 mem_wdata SHALL replicate in_sdata[7:0] for SB, in_sdata[15:0] for SH and in_sdata[31:0] for SW across the whole bus.
REQ-013 mem_ack in ACCESS SHALL deassert mem_req on the next edge, set wb_valid=1 on that cycle, and return the FSM to IDLE; a 1-cycle-ack load therefore completes with wb_valid 2 cycles after accept.
REQ-014 Load data SHALL be selected from mem_rdata at the lane: LB/LH sign-extend to DATA_W; LBU/LHU zero-extend; LW on DATA_W=64 sign-extends 32 bits; LW on DATA_W=32 passes through unchanged.
REQ-015 Loads SHALL set wb_wr=in_wr; stores SHALL set wb_wr=0 and wb_data=0.
REQ-016 wb_wr SHALL be forced to 0 whenever wb_addr=0 (register r0).
REQ-017 Timeout counter SHALL clear at entry to ACCESS and increment each mem_req cycle without ack.
REQ-018 When the count reaches TIMEOUT without ack, mem_req SHALL drop on the next edge, with wb_valid=1, exc_bus=1, wb_wr=0, and the FSM returning to IDLE.
REQ-019 mem_ack and the timeout SHALL be evaluated on the same edge; mem_ack wins.
REQ-020 mem_ack received in IDLE SHALL be ignored.
REQ-021 exc_align and exc_bus SHALL never both be 1; both SHALL be 0 whenever wb_valid=0.

Reset
REQ-022 On rst=1 at a clock edge, all of the following SHALL be forced: FSM=IDLE; counter=0; mem_req, mem_we, wb_valid, wb_wr, exc_align, exc_bus = 0; mem_be=0; mem_addr, mem_wdata, wb_data, wb_addr = 0; in_ready SHALL be 0 while rst=1.
REQ-023 Reset during ACCESS SHALL abandon the transaction: mem_req=0 the following cycle, and no wb_valid is produced for it.

Verification
REQ-024 PASS back-to-back: 3 consecutive ops with in_waddr 3, 0, 7 and in_wr=1 -> 3 consecutive wb_valid pulses; wb_wr = 1, 0, 1.
REQ-025 LB with in_addr=0x1003, mem_rdata=0x80FF_FF11, ack after 3 cycles -> mem_addr=0x1000, mem_be=1000b, wb_data=0xFFFF_FF80; LBU of the same -> 0x0000_0080.
REQ-026 SH with in_addr=0x2002, in_sdata=0x1234_ABCD -> mem_we=1, mem_be=1100b, mem_wdata=0xABCD_ABCD, wb_wr=0.
REQ-027 LW with in_addr=0x0006 -> no mem_req; wb_valid=1 with exc_align=1 one cycle after accept.
REQ-028 TIMEOUT=4, mem_ack never asserted -> mem_req high for exactly 4 cycles, then exc_bus=1; a repeat of the same case with mem_ack on the 4th cycle -> normal completion with exc_bus=0.
REQ-029 rst pulse in the 2nd ACCESS cycle -> mem_req=0 the following cycle, no wb_valid, and in_ready=1 after rst is released.
